// File: rtl/evt_window_ctrl.sv
// evt_window_ctrl: time-shares one 16-bit event counter across NUM_CH sources, one gate window per channel.
// Define EVT_WINDOW_SAT_EN to make the counter saturate at MAX_COUNT-1 instead of wrapping.
module evt_window_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int GATE_CYCLES = 10_000,
    parameter int MAX_COUNT   = 40_000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic                      abort_in,
    input  logic                      cont_in,
    input  logic [NUM_CH-1:0]         evt_in,
    output logic                      busy_out,
    output logic                      result_valid_out,
    input  logic                      result_ready_in,
    output logic [$clog2(NUM_CH)-1:0] result_ch_out,
    output logic [15:0]               result_count_out,
    output logic                      result_ovf_out
);
    localparam int CW = $clog2(NUM_CH);
    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [15:0]   CNT_MAX = 16'(MAX_COUNT - 1);
    localparam logic [TW-1:0] TMR_END = TW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, GATE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d, rch_q, rch_d;
    logic [15:0]     cnt_q, cnt_d, rcnt_q, rcnt_d, cnt_inc;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            ovf_q, ovf_d, vld_q, vld_d, rovf_q, rovf_d;
    logic            hit, at_max;

    assign hit    = evt_in[ch_q];
    assign at_max = cnt_q == CNT_MAX;
`ifdef EVT_WINDOW_SAT_EN
    assign cnt_inc = at_max ? cnt_q : cnt_q + 16'd1;
`else
    assign cnt_inc = at_max ? 16'd0 : cnt_q + 16'd1;
`endif

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        rch_d   = rch_q;
        rcnt_d  = rcnt_q;
        rovf_d  = rovf_q;
        if (abort_in) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            rch_d   = '0;
            rcnt_d  = '0;
            rovf_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_in) begin
                    state_d = GATE;
                    ch_d    = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    ovf_d   = 1'b0;
                end
                GATE: begin
                    tmr_d = tmr_q + TW'(1);
                    cnt_d = hit ? cnt_inc : cnt_q;
                    ovf_d = ovf_q | (hit & at_max);
                    // the final gate cycle's event is already folded into cnt_d/ovf_d
                    if (tmr_q == TMR_END) begin
                        state_d = HOLD;
                        vld_d   = 1'b1;
                        rch_d   = ch_q;
                        rcnt_d  = cnt_d;
                        rovf_d  = ovf_d;
                    end
                end
                HOLD: if (vld_q && result_ready_in) begin
                    vld_d = 1'b0;
                    if (ch_q == CH_LAST && !cont_in) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GATE;
                        ch_d    = ch_q == CH_LAST ? '0 : ch_q + CW'(1);
                        cnt_d   = '0;
                        tmr_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            rch_q   <= '0;
            rcnt_q  <= '0;
            rovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            rch_q   <= rch_d;
            rcnt_q  <= rcnt_d;
            rovf_q  <= rovf_d;
        end
    end

    assign busy_out         = state_q != IDLE;
    assign result_valid_out = vld_q;
    assign result_ch_out    = rch_q;
    assign result_count_out = rcnt_q;
    assign result_ovf_out   = rovf_q;
endmodule

// File: doc/evt_window_ctrl.md
# evt_window_ctrl

Measurement scheduler that time-shares one internal 16-bit event counter among `NUM_CH` event sources. Each channel is counted in turn over a fixed gate window of `GATE_CYCLES` clocks. Each window's result is handed downstream with a channel tag over a valid/ready interface. It sits between the per-source event strobes and the readout/display logic, which consumes one tagged count per window.

## Interface
- `NUM_CH`, default 4: number of event sources; legal range 2..16.
- `GATE_CYCLES`, default 10_000: gate window length in clocks; legal range 2..2^24.
- `MAX_COUNT`, default 40_000: count modulus; legal range 2..65536.
- `clk_in` input 1: single clock; all logic is on its rising edge.
- `rst_in` input 1: asynchronous, active-high reset.
- `start_in` input 1: single-cycle request to begin a scan at channel 0. Honoured only in IDLE.
- `abort_in` input 1: synchronous abort to IDLE from any state.
- `cont_in` input 1: level input. If 1, the scan wraps from the last channel back to channel 0 indefinitely.
- `evt_in` input `NUM_CH`: synchronous event strobes. Each cycle a bit is 1 counts as one event.
- `busy_out` output 1: 1 in any state other than IDLE.
- `result_valid_out` output 1: result holding registers are valid.
- `result_ready_in` input 1: downstream accepts the result.
- `result_ch_out` output `$clog2(NUM_CH)`: channel index of the held result.
- `result_count_out` output 16: event count for that window.
- `result_ovf_out` output 1: count reached `MAX_COUNT`-1 and received a further event during the window.

## Operation
- Reset:
  - State is IDLE, active channel is 0, counter is 0, gate timer is 0.
  - All outputs are 0.
  - Reset is honoured mid-window and mid-handshake; no partial result survives.
- IDLE:
  - `start_in`=1 clears the counter, gate timer and overflow flag, sets channel to 0, then goes to GATE.
- GATE:
  - Every cycle, the gate timer increments.
  - If `evt_in[ch]`=1, the counter advances. All other `evt_in` bits are ignored.
  - Counter at `MAX_COUNT`-1 plus an event: counter wraps to 0 and the sticky overflow flag is set.
  - On the cycle the timer equals `GATE_CYCLES`-1:
    - An event on that cycle is counted.
    - ch, the final count and the overflow flag are registered into the result outputs.
    - `result_valid_out` is set and the state goes to HOLD.
- HOLD:
  - Events are ignored and the result outputs are stable.
  - On `result_valid_out`=1 and `result_ready_in`=1, valid clears next cycle.
  - If ch=`NUM_CH`-1 and `cont_in`=0, go to IDLE.
  - Otherwise, ch increments (wrapping `NUM_CH`-1 to 0), the counter, timer and flag are cleared, and the state goes to GATE.
  - `cont_in` is sampled only on that handshake cycle.
- `abort_in`:
  - Has highest priority after reset.
  - Next state is IDLE, `result_valid_out` clears, and any held result is discarded.
  - `start_in` arriving in the same cycle is ignored.
- `start_in` outside IDLE is ignored.
- Width rules:
  - The counter is 16 bits and compares against `MAX_COUNT`-1.
  - The timer is `$clog2(GATE_CYCLES)` bits.
  - Results are zero-extended to 16 bits.

## Timing
- `start_in` is sampled in cycle 0. GATE counts in cycles 1..`GATE_CYCLES`, i.e. exactly `GATE_CYCLES` cycles per window.
- `result_valid_out` rises in cycle `GATE_CYCLES`+1.
- With `result_ready_in` held at 1:
  - The handshake completes in cycle `GATE_CYCLES`+1.
  - The next window counts from cycle `GATE_CYCLES`+2.
  - Per-channel period is `GATE_CYCLES`+1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `busy_out` falls the cycle after the final handshake or after an abort.

## Configuration
- `EVT_WINDOW_SAT_EN` defined:
  - The counter saturates at `MAX_COUNT`-1 instead of wrapping.
  - `result_ovf_out` is still set on the first event lost at saturation.
- `EVT_WINDOW_SAT_EN` undefined:
  - Wrap behaviour as described under Operation (the default).

## Test plan
Parameters for all scenarios: `NUM_CH`=4, `GATE_CYCLES`=8, `MAX_COUNT`=5, ready tied to 1 unless stated.
- Single scan, `cont_in`=0, with `evt_in[k]` held high for k+1 gate cycles of window k:
  - Four results: ch 0..3 with counts 1,2,3,4.
  - No ovf.
  - First valid at cycle 9, valids spaced 9 cycles apart, `busy_out` low after the 4th handshake.
- Channel isolation: all `evt_in` bits high except `evt_in[2]`=0 → ch 2 reports count 0, ovf 1 on the others.
- Overflow, `evt_in[0]` high for all 8 cycles:
  - Without the macro: count 3 (8 mod 5), ovf=1.
  - With `EVT_WINDOW_SAT_EN`: count 4, ovf=1.
- Backpressure on the ch 1 result:
  - Hold ready at 0 for 5 cycles → result stable, events in HOLD not counted.
  - Ch 2 window starts the cycle after ready rises.
- `cont_in`=1 → after ch 3, ch 0 reappears with a fresh count.
  - Then `abort_in` mid-window → next cycle IDLE, valid 0.
  - `start_in` in the same cycle as the abort is ignored.
- Async `rst_in` asserted mid-GATE and in HOLD → all outputs 0 immediately.
  - A subsequent start reports ch 0 correctly.
